// File: rtl/sync_vg_if.sv
// -----------------------------------------------------------------------------
// sync_vg_if
//
// Video timing bus produced by sync_vg and consumed by the pattern/plot
// generator on the same pixel clock domain.
//
// Signals:
//   vs_out      vertical sync (asserted level set by the generator's VS_POL)
//   hs_out      horizontal sync (asserted level set by the generator's HS_POL)
//   de_out      data enable, high inside the active window
//   act_x       active pixel column, valid while de_out is high, else 0
//   act_y       active line, valid while de_out is high, else 0
//   frame_start one-cycle pulse on the first output cycle of each frame
//   frame_cnt   frame counter (all zero unless the counter is built in)
//
// Modports:
//   master  timing generator side (drives everything)
//   slave   downstream consumer side (samples everything)
//
// There is no handshake on this bus: the generator is free running and the
// consumer must take every beat. de_out, act_x and act_y are registered
// together, so a consumer samples all three on the same edge.
// -----------------------------------------------------------------------------
interface sync_vg_if #(
    parameter int X_BITS = 13,
    parameter int Y_BITS = 13
);
    logic              vs_out;
    logic              hs_out;
    logic              de_out;
    logic [X_BITS-1:0] act_x;
    logic [Y_BITS-1:0] act_y;
    logic              frame_start;
    logic [15:0]       frame_cnt;

    modport master (
        output vs_out,
        output hs_out,
        output de_out,
        output act_x,
        output act_y,
        output frame_start,
        output frame_cnt
    );

    modport slave (
        input vs_out,
        input hs_out,
        input de_out,
        input act_x,
        input act_y,
        input frame_start,
        input frame_cnt
    );
endinterface

// File: rtl/sync_vg.sv
// -----------------------------------------------------------------------------
// sync_vg
//
// Free-running video timing generator. Horizontal and vertical counters walk
// sync, back porch, active and front porch on each axis; hs/vs/de and the
// active-region coordinates are derived from the counters and registered, so
// every output appears one cycle after the counter value it describes.
// Defaults give CEA 1280x720@60 at 74.25 MHz.
//
// Ports:
//   pix_clk  in   pixel clock, the only clock
//   rst      in   synchronous, active-high reset
//   vid      sync_vg_if.master  vs_out, hs_out, de_out, act_x, act_y,
//                               frame_start, frame_cnt
//
// Build option:
//   SYNC_VG_FRAME_CNT_EN  when defined, frame_cnt counts registered
//                         frame_start pulses (wrapping at 16 bits); when not
//                         defined frame_cnt is tied to zero and the counter is
//                         not built.
// -----------------------------------------------------------------------------
module sync_vg #(
    parameter int   X_BITS = 13,
    parameter int   Y_BITS = 13,
    parameter int   H_SYNC = 40,
    parameter int   H_BP   = 220,
    parameter int   H_ACT  = 1280,
    parameter int   H_FP   = 110,
    parameter int   V_SYNC = 5,
    parameter int   V_BP   = 20,
    parameter int   V_ACT  = 720,
    parameter int   V_FP   = 5,
    parameter logic HS_POL = 1'b1,
    parameter logic VS_POL = 1'b1
) (
    input  logic       pix_clk,
    input  logic       rst,
    sync_vg_if.master  vid
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

    // Thresholds expressed as inclusive "last" values in counter width, so an
    // empty front porch never needs a value equal to 2**X_BITS.
    localparam logic [X_BITS-1:0] H_LAST      = X_BITS'(H_TOTAL - 1);
    localparam logic [X_BITS-1:0] H_SYNC_LAST = X_BITS'(H_SYNC - 1);
    localparam logic [X_BITS-1:0] H_ACT_FIRST = X_BITS'(H_SYNC + H_BP);
    localparam logic [X_BITS-1:0] H_ACT_LAST  = X_BITS'(H_SYNC + H_BP + H_ACT - 1);

    localparam logic [Y_BITS-1:0] V_LAST      = Y_BITS'(V_TOTAL - 1);
    localparam logic [Y_BITS-1:0] V_SYNC_LAST = Y_BITS'(V_SYNC - 1);
    localparam logic [Y_BITS-1:0] V_ACT_FIRST = Y_BITS'(V_SYNC + V_BP);
    localparam logic [Y_BITS-1:0] V_ACT_LAST  = Y_BITS'(V_SYNC + V_BP + V_ACT - 1);

    // Elaboration-time parameter sanity checks.
    if (H_TOTAL > (1 << X_BITS)) begin : g_chk_h_total
        $error("sync_vg: H_TOTAL=%0d does not fit in X_BITS=%0d", H_TOTAL, X_BITS);
    end
    if (V_TOTAL > (1 << Y_BITS)) begin : g_chk_v_total
        $error("sync_vg: V_TOTAL=%0d does not fit in Y_BITS=%0d", V_TOTAL, Y_BITS);
    end
    if (H_SYNC < 1 || H_ACT < 1 || V_SYNC < 1 || V_ACT < 1) begin : g_chk_seg
        $error("sync_vg: sync and active segments must be at least one long");
    end

    // Counters
    logic [X_BITS-1:0] h_cnt_q, h_cnt_d;
    logic [Y_BITS-1:0] v_cnt_q, v_cnt_d;

    // Registered outputs
    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic              de_q, de_d;
    logic [X_BITS-1:0] act_x_q, act_x_d;
    logic [Y_BITS-1:0] act_y_q, act_y_d;
    logic              frame_start_q, frame_start_d;

    logic h_last;
    logic v_last;
    logic h_in_act;
    logic v_in_act;

    always_comb begin
        h_last   = (h_cnt_q == H_LAST);
        v_last   = (v_cnt_q == V_LAST);

        h_cnt_d  = h_last ? '0 : h_cnt_q + 1'b1;
        v_cnt_d  = v_cnt_q;
        if (h_last) begin
            // Line and frame wrap together on the last pixel of the frame.
            v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
        end

        h_in_act = (h_cnt_q >= H_ACT_FIRST) && (h_cnt_q <= H_ACT_LAST);
        v_in_act = (v_cnt_q >= V_ACT_FIRST) && (v_cnt_q <= V_ACT_LAST);

        // vs depends only on v_cnt, so its edges land on h_cnt == 0.
        hs_d          = (h_cnt_q <= H_SYNC_LAST) ? HS_POL : ~HS_POL;
        vs_d          = (v_cnt_q <= V_SYNC_LAST) ? VS_POL : ~VS_POL;
        de_d          = h_in_act && v_in_act;
        // Subtraction only used while de_d is high, so it never underflows.
        act_x_d       = de_d ? (h_cnt_q - H_ACT_FIRST) : '0;
        act_y_d       = de_d ? (v_cnt_q - V_ACT_FIRST) : '0;
        frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            de_q          <= 1'b0;
            act_x_q       <= '0;
            act_y_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            de_q          <= de_d;
            act_x_q       <= act_x_d;
            act_y_q       <= act_y_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef SYNC_VG_FRAME_CNT_EN
    // Counts registered frame_start pulses, so the first frame after reset
    // reads 1 from the cycle after its pulse.
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            frame_cnt_q <= 16'h0000;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign vid.frame_cnt = frame_cnt_q;
`else
    assign vid.frame_cnt = 16'h0000;
`endif

    assign vid.hs_out      = hs_q;
    assign vid.vs_out      = vs_q;
    assign vid.de_out      = de_q;
    assign vid.act_x       = act_x_q;
    assign vid.act_y       = act_y_q;
    assign vid.frame_start = frame_start_q;

endmodule

// File: tb/tb_sync_vg.sv
// -----------------------------------------------------------------------------
// tb_sync_vg
//
// Two generators share clock and reset: one with the default 720p timing
// (first line and first active line are walked), one with a tiny raster and
// active-low syncs so whole frames and a mid-frame reset fit in a short run.
//
// Small raster: H = 4 sync, 3 bp, 8 act, 2 fp (17); V = 2 sync, 2 bp, 4 act,
// 1 fp (9); 153 cycles per frame. Output sample index i (counted from the
// first cycle after reset release) reflects h = i % 17, v = (i / 17) % 9.
// -----------------------------------------------------------------------------
module tb_sync_vg;

    logic pix_clk;
    logic rst;

    int n_vec;
    int n_err;

`ifdef SYNC_VG_FRAME_CNT_EN
    localparam int FC1 = 1;
    localparam int FC2 = 2;
    localparam int FC3 = 3;
`else
    localparam int FC1 = 0;
    localparam int FC2 = 0;
    localparam int FC3 = 0;
`endif

    sync_vg_if #(.X_BITS(13), .Y_BITS(13)) d_if ();
    sync_vg_if #(.X_BITS(5),  .Y_BITS(4))  s_if ();

    sync_vg u_dut_d (
        .pix_clk (pix_clk),
        .rst     (rst),
        .vid     (d_if.master)
    );

    sync_vg #(
        .X_BITS (5),
        .Y_BITS (4),
        .H_SYNC (4),
        .H_BP   (3),
        .H_ACT  (8),
        .H_FP   (2),
        .V_SYNC (2),
        .V_BP   (2),
        .V_ACT  (4),
        .V_FP   (1),
        .HS_POL (1'b0),
        .VS_POL (1'b0)
    ) u_dut_s (
        .pix_clk (pix_clk),
        .rst     (rst),
        .vid     (s_if.master)
    );

    // Clock / reset
    initial begin
        pix_clk = 1'b0;
        forever #5 pix_clk = ~pix_clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected run to finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge pix_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_s_reset(input string tag);
        chk({tag, "_hs"},  32'(s_if.hs_out), 1);
        chk({tag, "_vs"},  32'(s_if.vs_out), 1);
        chk({tag, "_de"},  32'(s_if.de_out), 0);
        chk({tag, "_ax"},  32'(s_if.act_x), 0);
        chk({tag, "_ay"},  32'(s_if.act_y), 0);
        chk({tag, "_fs"},  32'(s_if.frame_start), 0);
        chk({tag, "_fc"},  32'(s_if.frame_cnt), 0);
    endtask

    initial begin
        int hs_n;
        int de_n;
        int first_low;
        int run;
        int last_x;
        int last_y;
        int fs_n;

        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;

        // Reset held 4 cycles
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("d_rst_hs", 32'(d_if.hs_out), 0);
            chk("s_rst_hs", 32'(s_if.hs_out), 1);
        end
        chk("d_rst_vs", 32'(d_if.vs_out), 0);
        chk("d_rst_de", 32'(d_if.de_out), 0);
        chk("d_rst_ax", 32'(d_if.act_x), 0);
        chk("d_rst_ay", 32'(d_if.act_y), 0);
        chk("d_rst_fs", 32'(d_if.frame_start), 0);
        chk("d_rst_fc", 32'(d_if.frame_cnt), 0);
        chk_s_reset("s_rst");

        // First edge after release: default sample index 0 (h=0, v=0)
        rst = 1'b0;
        tick();
        chk("d_rel_hs", 32'(d_if.hs_out), 1);
        chk("d_rel_vs", 32'(d_if.vs_out), 1);
        chk("d_rel_fs", 32'(d_if.frame_start), 1);
        chk("d_rel_de", 32'(d_if.de_out), 0);
        chk("s_rel_hs", 32'(s_if.hs_out), 0);
        chk("s_rel_vs", 32'(s_if.vs_out), 0);
        chk("s_rel_fs", 32'(s_if.frame_start), 1);

        // Default raster, first line
        hs_n      = 0;
        de_n      = 0;
        first_low = -1;
        for (int i = 0; i < 1650; i++) begin
            if (d_if.hs_out) hs_n++;
            else if (first_low < 0) first_low = i;
            if (d_if.de_out) de_n++;
            tick();
        end
        // Index 1650: h=0, v=1
        chk("d_hs_width",     hs_n, 40);
        chk("d_hs_first_low", first_low, 40);
        chk("d_line0_de",     de_n, 0);
        chk("d_line1_hs",     32'(d_if.hs_out), 1);
        chk("d_line1_vs",     32'(d_if.vs_out), 1);
        chk("d_line1_fs",     32'(d_if.frame_start), 0);

        // Walk to v=25, h=259 (index 41509)
        repeat (41509 - 1650) tick();
        chk("d_pre_act_de", 32'(d_if.de_out), 0);
        chk("d_v25_vs",     32'(d_if.vs_out), 0);
        tick();
        chk("d_act0_de", 32'(d_if.de_out), 1);
        chk("d_act0_ax", 32'(d_if.act_x), 0);
        chk("d_act0_ay", 32'(d_if.act_y), 0);
        run    = 0;
        last_x = -1;
        last_y = -1;
        for (int i = 0; i < 2000 && d_if.de_out; i++) begin
            run++;
            last_x = int'(d_if.act_x);
            last_y = int'(d_if.act_y);
            tick();
        end
        chk("d_de_run",     run, 1280);
        chk("d_de_last_ax", last_x, 1279);
        chk("d_de_last_ay", last_y, 0);
        chk("d_fp_de",      32'(d_if.de_out), 0);
        chk("d_fp_ax",      32'(d_if.act_x), 0);

        // Small raster: restart both generators with a 1-cycle reset
        rst = 1'b1;
        tick();
        chk_s_reset("s_rst2");
        rst = 1'b0;
        tick();

        fs_n = 0;
        de_n = 0;
        for (int i = 0; i < 460; i++) begin
            if (s_if.frame_start) begin
                fs_n++;
                chk("s_fs_pos", i % 153, 0);
            end
            if (s_if.de_out && i < 459) de_n++;
            case (i)
                0: begin
                    chk("s_i0_fs", 32'(s_if.frame_start), 1);
                    chk("s_i0_hs", 32'(s_if.hs_out), 0);
                    chk("s_i0_vs", 32'(s_if.vs_out), 0);
                    chk("s_i0_de", 32'(s_if.de_out), 0);
                    chk("s_i0_fc", 32'(s_if.frame_cnt), 0);
                end
                1: begin
                    chk("s_i1_fs", 32'(s_if.frame_start), 0);
                    chk("s_i1_fc", 32'(s_if.frame_cnt), FC1);
                end
                3:   chk("s_h3_hs", 32'(s_if.hs_out), 0);
                4:   chk("s_h4_hs", 32'(s_if.hs_out), 1);
                33:  chk("s_v1_vs", 32'(s_if.vs_out), 0);
                34:  chk("s_v2_vs", 32'(s_if.vs_out), 1);
                74:  chk("s_pre_act_de", 32'(s_if.de_out), 0);
                75: begin
                    chk("s_act0_de", 32'(s_if.de_out), 1);
                    chk("s_act0_ax", 32'(s_if.act_x), 0);
                    chk("s_act0_ay", 32'(s_if.act_y), 0);
                end
                78: begin
                    chk("s_78_ax", 32'(s_if.act_x), 3);
                    chk("s_78_ay", 32'(s_if.act_y), 0);
                end
                82: begin
                    chk("s_82_de", 32'(s_if.de_out), 1);
                    chk("s_82_ax", 32'(s_if.act_x), 7);
                end
                83: begin
                    chk("s_83_de", 32'(s_if.de_out), 0);
                    chk("s_83_ax", 32'(s_if.act_x), 0);
                end
                88:  chk("s_88_ax", 32'(s_if.act_x), 0);
                111: begin
                    chk("s_111_ax", 32'(s_if.act_x), 2);
                    chk("s_111_ay", 32'(s_if.act_y), 2);
                end
                133: begin
                    chk("s_last_de", 32'(s_if.de_out), 1);
                    chk("s_last_ax", 32'(s_if.act_x), 7);
                    chk("s_last_ay", 32'(s_if.act_y), 3);
                end
                134: chk("s_134_de", 32'(s_if.de_out), 0);
                136: begin
                    chk("s_fp_de", 32'(s_if.de_out), 0);
                    chk("s_fp_vs", 32'(s_if.vs_out), 1);
                end
                154: chk("s_fc2", 32'(s_if.frame_cnt), FC2);
                307: chk("s_fc3", 32'(s_if.frame_cnt), FC3);
                default: ;
            endcase
            tick();
        end
        chk("s_fs_count", fs_n, 4);
        chk("s_de_count", de_n, 96);

        // Index 460 is frame index 1; walk to frame index 95 (v=5, h=10)
        repeat (94) tick();
        chk("s_mid_de", 32'(s_if.de_out), 1);
        chk("s_mid_ax", 32'(s_if.act_x), 3);
        chk("s_mid_ay", 32'(s_if.act_y), 1);

        // Mid-frame reset
        rst = 1'b1;
        tick();
        chk_s_reset("s_mid_rst");
        rst = 1'b0;
        tick();
        chk("s_restart_fs", 32'(s_if.frame_start), 1);
        chk("s_restart_hs", 32'(s_if.hs_out), 0);
        chk("s_restart_vs", 32'(s_if.vs_out), 0);
        chk("s_restart_de", 32'(s_if.de_out), 0);
        tick();
        chk("s_restart1_fs", 32'(s_if.frame_start), 0);
        chk("s_restart1_fc", 32'(s_if.frame_cnt), FC1);
        repeat (74) tick();
        chk("s_restart_act_de", 32'(s_if.de_out), 1);
        chk("s_restart_act_ax", 32'(s_if.act_x), 0);
        chk("s_restart_act_ay", 32'(s_if.act_y), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
